conv_last_to_first_mc: RTL and testbench

- Multi-channel, flow-controlled successor of the single-stream last-to-first converter.
- Accepts interleaved beats from n_chan independent packet streams, each tagged with a channel id and a 'last' flag.
- Emits the same beats with per-channel 'first', the original 'last', and a per-channel beat index.
- Sits between a channel-interleaving upstream source and downstream consumers that need packet-start framing.
- Uses a valid/ready handshake with one registered output stage.

---
 rtl/conv_last_to_first_mc.sv | 129 ++++++++++++
 tb/tb_conv_last_to_first_mc.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_last_to_first_mc.sv
// Multi-channel last-to-first converter: tags interleaved beats with per-channel
// first flag and beat index, behind one registered valid/ready output stage.
module conv_last_to_first_mc #(
    parameter int width = 8,
    parameter int n_chan = 4,
    parameter int idx_w = 8,
    localparam int chan_w = (n_chan > 1) ? $clog2(n_chan) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [chan_w-1:0] up_chan,
    input  logic              up_last,
    input  logic [width-1:0]  up_data,
    output logic              down_valid,
    input  logic              down_ready,
    output logic [chan_w-1:0] down_chan,
    output logic              down_first,
    output logic              down_last,
    output logic [idx_w-1:0]  down_index,
    output logic [width-1:0]  down_data
);

    localparam logic [chan_w:0] n_chan_ext = (chan_w + 1)'(n_chan);

    logic              first_pending_q [n_chan];
    logic              first_pending_d [n_chan];
    logic [idx_w-1:0]  beat_cnt_q [n_chan];
    logic [idx_w-1:0]  beat_cnt_d [n_chan];

    logic              down_valid_q, down_valid_d;
    logic [chan_w-1:0] down_chan_q, down_chan_d;
    logic              down_first_q, down_first_d;
    logic              down_last_q, down_last_d;
    logic [idx_w-1:0]  down_index_q, down_index_d;
    logic [width-1:0]  down_data_q, down_data_d;

    logic              ready_c;
    logic              chan_ok;
    logic              accept;
    logic              sel_first;
    logic [idx_w-1:0]  sel_cnt;
    logic [idx_w-1:0]  cnt_inc;
    logic [idx_w-1:0]  next_cnt;

    always_comb begin
        ready_c = ~reset & (~down_valid_q | down_ready);
        // Ids beyond n_chan are consumed but never reach the channel state or output.
        chan_ok = ({1'b0, up_chan} < n_chan_ext);
        accept  = up_valid & ready_c & chan_ok;

        sel_first = 1'b0;
        sel_cnt   = '0;
        for (int c = 0; c < n_chan; c++) begin
            if (int'(up_chan) == c) begin
                sel_first = first_pending_q[c];
                sel_cnt   = beat_cnt_q[c];
            end
        end

        cnt_inc  = (&sel_cnt) ? sel_cnt : sel_cnt + idx_w'(1);
        next_cnt = up_last ? '0 : (sel_first ? idx_w'(1) : cnt_inc);

        first_pending_d = first_pending_q;
        beat_cnt_d      = beat_cnt_q;
        down_valid_d    = down_valid_q;
        down_chan_d     = down_chan_q;
        down_first_d    = down_first_q;
        down_last_d     = down_last_q;
        down_index_d    = down_index_q;
        down_data_d     = down_data_q;

        // Emptied stage zeroes its payload fields; the channel id keeps its last value.
        if (down_valid_q && down_ready) begin
            down_valid_d = 1'b0;
            down_first_d = 1'b0;
            down_last_d  = 1'b0;
            down_index_d = '0;
            down_data_d  = '0;
        end

        if (accept) begin
            down_valid_d = 1'b1;
            down_chan_d  = up_chan;
            down_first_d = sel_first;
            down_last_d  = up_last;
            down_index_d = sel_first ? '0 : sel_cnt;
            down_data_d  = up_data;
            for (int c = 0; c < n_chan; c++) begin
                if (int'(up_chan) == c) begin
                    first_pending_d[c] = up_last;
                    beat_cnt_d[c]      = next_cnt;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            first_pending_q <= '{default: 1'b1};
            beat_cnt_q      <= '{default: '0};
            down_valid_q    <= 1'b0;
            down_chan_q     <= '0;
            down_first_q    <= 1'b0;
            down_last_q     <= 1'b0;
            down_index_q    <= '0;
            down_data_q     <= '0;
        end else begin
            first_pending_q <= first_pending_d;
            beat_cnt_q      <= beat_cnt_d;
            down_valid_q    <= down_valid_d;
            down_chan_q     <= down_chan_d;
            down_first_q    <= down_first_d;
            down_last_q     <= down_last_d;
            down_index_q    <= down_index_d;
            down_data_q     <= down_data_d;
        end
    end

    assign up_ready   = ready_c;
    assign down_valid = down_valid_q;
    assign down_chan  = down_chan_q;
    assign down_first = down_first_q;
    assign down_last  = down_last_q;
    assign down_index = down_index_q;
    assign down_data  = down_data_q;

endmodule

// File: tb/tb_conv_last_to_first_mc.sv
// Bench for conv_last_to_first_mc: three configurations (default, idx_w=2, n_chan=3)
// checked by directed tables, hand sequences and a random run against a packet-position model.
module tb_conv_last_to_first_mc;

    localparam int NI = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       uv [NI];
    logic       ul [NI];
    logic       dr [NI];
    logic [1:0] uc [NI];
    logic [7:0] ud [NI];
    logic       ur [NI];
    logic       dv [NI];
    logic       df [NI];
    logic       dl [NI];
    logic [1:0] dc [NI];
    logic [7:0] dd [NI];
    logic [7:0] di [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int IW = (g == 1) ? 2 : 8;
        localparam int NC = (g == 2) ? 3 : 4;
        logic [IW-1:0] idx;
        conv_last_to_first_mc #(.width(8), .n_chan(NC), .idx_w(IW)) u_dut (
            .clock(clock), .reset(reset),
            .up_valid(uv[g]), .up_ready(ur[g]), .up_chan(uc[g]),
            .up_last(ul[g]), .up_data(ud[g]),
            .down_valid(dv[g]), .down_ready(dr[g]), .down_chan(dc[g]),
            .down_first(df[g]), .down_last(dl[g]), .down_index(idx),
            .down_data(dd[g])
        );
        assign di[g] = 8'(idx);
    end

    function automatic int nch(input int i);
        return (i == 2) ? 3 : 4;
    endfunction

    function automatic int idx_max(input int i);
        return (i == 1) ? 3 : 255;
    endfunction

    // Reference: each channel tracks its position inside the current packet.
    typedef struct {
        logic       first;
        logic       last;
        logic [7:0] idx;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q [NI][$];
    int         pos [NI][4];
    logic [1:0] exp_chan [NI];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    function automatic void model_accept(input int i, input logic [1:0] c, input logic l, input logic [7:0] d);
        beat_t b;
        if (int'(c) >= nch(i)) return;
        b.first = (pos[i][c] == 0);
        b.idx   = 8'((pos[i][c] < idx_max(i)) ? pos[i][c] : idx_max(i));
        b.last  = l;
        b.data  = d;
        exp_q[i].push_back(b);
        exp_chan[i] = c;
        pos[i][c] = l ? 0 : pos[i][c] + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            exp_chan[i] = 2'd0;
            for (int c = 0; c < 4; c++) pos[i][c] = 0;
        end
    endtask

    // Inputs are set at the falling edge; this samples, advances one clock, returns at the next falling edge.
    task automatic cycle();
        logic dtx [NI];
        logic acc [NI];
        logic rst_s;
        logic full;
        #1;
        rst_s = reset;
        for (int i = 0; i < NI; i++) begin
            full = (exp_q[i].size() != 0);
            chk("up_ready", i, ur[i], !reset && (!full || dr[i]));
            chk("down_valid", i, dv[i], full);
            chk("down_chan", i, dc[i], exp_chan[i]);
            if (full) begin
                chk("down_first", i, df[i], exp_q[i][0].first);
                chk("down_last", i, dl[i], exp_q[i][0].last);
                chk("down_index", i, di[i], exp_q[i][0].idx);
                chk("down_data", i, dd[i], exp_q[i][0].data);
            end else begin
                chk("idle_zero", i, {df[i], dl[i], di[i], dd[i]}, 32'd0);
            end
            dtx[i] = full && dr[i];
            acc[i] = uv[i] && !reset && (!full || dr[i]);
        end
        @(posedge clock);
        if (rst_s) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (dtx[i]) void'(exp_q[i].pop_front());
                if (acc[i]) model_accept(i, uc[i], ul[i], ud[i]);
            end
        end
        @(negedge clock);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            uv[i] = 1'b0; ul[i] = 1'b0; uc[i] = 2'd0; ud[i] = 8'd0; dr[i] = 1'b1;
        end
    endtask

    typedef struct {
        int         inst;
        logic       v;
        logic [1:0] c;
        logic       l;
        logic [7:0] d;
        logic       r;
        logic       e_v;
        logic       e_f;
        logic       e_l;
        logic [7:0] e_i;
        logic [7:0] e_d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mkv(input int inst, input logic v, input logic [1:0] c, input logic l,
                                 input logic [7:0] d, input logic ev, input logic ef, input logic el,
                                 input logic [7:0] ei, input logic [7:0] ed);
        vec_t t;
        t.inst = inst; t.v = v; t.c = c; t.l = l; t.d = d; t.r = 1'b1;
        t.e_v = ev; t.e_f = ef; t.e_l = el; t.e_i = ei; t.e_d = ed;
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Channel 0 only, three-beat packet then a single-beat packet.
        tbl.push_back(mkv(0, 1, 0, 0, 8'h10, 1, 1, 0, 0, 8'h10));
        tbl.push_back(mkv(0, 1, 0, 0, 8'h11, 1, 0, 0, 1, 8'h11));
        tbl.push_back(mkv(0, 1, 0, 1, 8'h12, 1, 0, 1, 2, 8'h12));
        tbl.push_back(mkv(0, 1, 0, 1, 8'h20, 1, 1, 1, 0, 8'h20));
        tbl.push_back(mkv(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
        // Interleaved channels 1 and 2.
        tbl.push_back(mkv(0, 1, 1, 0, 8'hA0, 1, 1, 0, 0, 8'hA0));
        tbl.push_back(mkv(0, 1, 2, 0, 8'hB0, 1, 1, 0, 0, 8'hB0));
        tbl.push_back(mkv(0, 1, 1, 1, 8'hA1, 1, 0, 1, 1, 8'hA1));
        tbl.push_back(mkv(0, 1, 2, 0, 8'hB1, 1, 0, 0, 1, 8'hB1));
        tbl.push_back(mkv(0, 1, 1, 0, 8'hA2, 1, 1, 0, 0, 8'hA2));
        tbl.push_back(mkv(0, 1, 1, 1, 8'hA3, 1, 0, 1, 1, 8'hA3));
        tbl.push_back(mkv(0, 1, 2, 1, 8'hB2, 1, 0, 1, 2, 8'hB2));
        tbl.push_back(mkv(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
        // idx_w=2: six-beat packet on channel 3 saturates at 3.
        tbl.push_back(mkv(1, 1, 3, 0, 8'h60, 1, 1, 0, 0, 8'h60));
        tbl.push_back(mkv(1, 1, 3, 0, 8'h61, 1, 0, 0, 1, 8'h61));
        tbl.push_back(mkv(1, 1, 3, 0, 8'h62, 1, 0, 0, 2, 8'h62));
        tbl.push_back(mkv(1, 1, 3, 0, 8'h63, 1, 0, 0, 3, 8'h63));
        tbl.push_back(mkv(1, 1, 3, 0, 8'h64, 1, 0, 0, 3, 8'h64));
        tbl.push_back(mkv(1, 1, 3, 1, 8'h65, 1, 0, 1, 3, 8'h65));
        tbl.push_back(mkv(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
        // n_chan=3: out-of-range id 3 between two channel-0 beats is dropped.
        tbl.push_back(mkv(2, 1, 0, 0, 8'h01, 1, 1, 0, 0, 8'h01));
        tbl.push_back(mkv(2, 1, 3, 0, 8'h99, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mkv(2, 1, 0, 1, 8'h02, 1, 0, 1, 1, 8'h02));
        tbl.push_back(mkv(2, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));

        model_reset();
        idle_all();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        cycle();
        reset = 1'b0;
        cycle();

        foreach (tbl[k]) begin
            idle_all();
            uv[tbl[k].inst] = tbl[k].v;
            uc[tbl[k].inst] = tbl[k].c;
            ul[tbl[k].inst] = tbl[k].l;
            ud[tbl[k].inst] = tbl[k].d;
            dr[tbl[k].inst] = tbl[k].r;
            cycle();
            chk("tbl_valid", tbl[k].inst, dv[tbl[k].inst], tbl[k].e_v);
            chk("tbl_first", tbl[k].inst, df[tbl[k].inst], tbl[k].e_f);
            chk("tbl_last", tbl[k].inst, dl[tbl[k].inst], tbl[k].e_l);
            chk("tbl_index", tbl[k].inst, di[tbl[k].inst], tbl[k].e_i);
            chk("tbl_data", tbl[k].inst, dd[tbl[k].inst], tbl[k].e_d);
        end

        // Backpressure: stall three cycles with upstream still offering a beat.
        idle_all();
        uv[0] = 1'b1; uc[0] = 2'd0; ud[0] = 8'h30; dr[0] = 1'b0;
        cycle();
        ud[0] = 8'h31;
        repeat (3) begin
            cycle();
            chk("bp_ready_low", 0, ur[0], 1'b0);
            chk("bp_hold_data", 0, dd[0], 8'h30);
            chk("bp_hold_first", 0, df[0], 1'b1);
        end
        dr[0] = 1'b1;
        cycle();
        chk("bp_release_data", 0, dd[0], 8'h31);
        chk("bp_release_index", 0, di[0], 8'd1);
        ud[0] = 8'h32; ul[0] = 1'b1;
        cycle();
        chk("bp_last_data", 0, dd[0], 8'h32);
        chk("bp_last_index", 0, di[0], 8'd2);
        idle_all();
        cycle();
        chk("bp_drained", 0, dv[0], 1'b0);

        // Reset in the middle of a channel-0 packet.
        uv[0] = 1'b1; uc[0] = 2'd0; ud[0] = 8'h40;
        cycle();
        ud[0] = 8'h41;
        cycle();
        ud[0] = 8'h42;
        reset = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < NI; i++) begin
            chk("rst_outputs", i, {dv[i], df[i], dl[i], dc[i], di[i], dd[i]}, 32'd0);
            chk("rst_ready", i, ur[i], 1'b0);
        end
        reset = 1'b0;
        ud[0] = 8'h55; ul[0] = 1'b1;
        cycle();
        chk("post_rst_first", 0, df[0], 1'b1);
        chk("post_rst_index", 0, di[0], 8'd0);
        chk("post_rst_data", 0, dd[0], 8'h55);
        idle_all();
        cycle();

        // Random traffic on all three configurations.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NI; i++) begin
                uv[i] = ($urandom_range(0, 9) < 7);
                uc[i] = 2'($urandom_range(0, 3));
                ul[i] = (i == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0);
                ud[i] = 8'($urandom);
                dr[i] = ($urandom_range(0, 9) < 7);
            end
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;
        idle_all();
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
